ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Parametrised pipeline carrier for the decoded control bundle (ALU op and source selects, immediate op, data-memory write-data source and write-enable, data-out source, register write-enable, branch/jump op). It takes the bundle from decode and moves it through `STAGES` registered stages (EX, MEM, WB, ...). Each stage carries a valid bit and has its own stall and flush controls. Side-effecting control bits are forced low on any bubble, so downstream units never see a write-enable from a killed or empty slot.

## Interface
- `CTRL_W`, default 24, width of the packed control bundle.
- `STAGES`, default 3, number of pipeline stages (range 1..8).
- `SE_MASK`, default `24'h000201`, bit mask of side-effecting bundle bits (reg_we, mem_d_we) that are gated by stage validity.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decode presents a valid bundle.
- `in_ctrl`  in  CTRL_W  bundle from decode.
- `in_ready`  out  1  stage 0 accepts this cycle.
- `stall`  in  STAGES  per-stage hold request; bit i belongs to stage i.
- `flush`  in  STAGES  per-stage kill; bit i belongs to stage i.
- `stage_valid`  out  STAGES  valid bit of each stage.
- `stage_ctrl`  out  STAGES*CTRL_W  stage i occupies bits `[i*CTRL_W +: CTRL_W]`, with SE_MASK gating applied.
- `parity_err`  out  STAGES  per-stage parity mismatch; exists in both build configurations.

## Operation
- Reset is asynchronous and active-low, on `clk`/`rst_n`. While `rst_n`=0:
  - all `stage_valid`=0;
  - all payload registers hold 0;
  - `parity_err`=0;
  - `in_ready` is driven from `stall` as in normal operation.
- hold[i] = OR of `stall[i..STAGES-1]`. A stall at stage k freezes stages 0..k.
- `in_ready` = !hold[0].
- Stage i next-state, priority high to low:
  1. `flush[i]`: valid ← 0; payload is don't-care and is retained.
  2. hold[i]: keep valid and payload.
  3. i=0: valid ← `in_valid`, payload ← `in_ctrl`.
  4. i>0 and (`stall[i-1]` or `flush[i-1]`): bubble, valid ← 0.
  5. Otherwise: valid and payload ← stage i-1.
- A flush kills the content of the stage it targets. That content is never forwarded, even if the next stage advances in the same cycle.
- Flushing a stage while it is held still clears it. Flush never releases a hold on other stages.
- Output gating: `stage_ctrl` slice i = payload[i] & ~(stage_valid[i] ? 0 : SE_MASK). Non-side-effect bits pass through unchanged.
- The last stage drains every cycle unless `stall[STAGES-1]` is set. There is no back-pressure beyond `stall`.
- `STAGES`=1 reduces to a single register with stall and flush.

## Timing
- Latency is 1 cycle per stage. A bundle accepted at edge N appears at stage i after edge N+i when there are no stalls.
- Throughput is 1 bundle per cycle when `stall`=0.
- `stall` and `flush` are sampled at the same edge as data and take effect on that edge. They have no combinational path to `stage_valid`/`stage_ctrl`.
- `in_ready` is combinational from `stall` only, with no dependence on `in_valid`.
- `stage_ctrl` is combinational from the registers (AND gating only).
- Reset assertion mid-stream clears all valids immediately, asynchronously. The first accept after deassertion is at the first rising edge with `rst_n`=1.

## Configuration
- `CTRL_PIPE_PARITY_EN` defined:
  - each stage stores one extra bit, the even parity of the payload computed at stage 0 entry and carried along with the payload;
  - `parity_err[i]` = stage_valid[i] & (^payload[i] != parity[i]), combinational.
- `CTRL_PIPE_PARITY_EN` undefined: no parity storage, and `parity_err` is tied to 0.

## Test plan
- Streaming, STAGES=3, stall=0: in_ctrl 0x11, 0x22, 0x33 on three consecutive cycles -> stage 2 shows 0x11, 0x22, 0x33 on cycles 3, 4, 5, each with stage_valid[2]=1.
- Middle stall: stall[1]=1 for 2 cycles while streaming -> stages 0-1 frozen, in_ready=0, stage 2 gets 2 bubbles with SE_MASK bits reading 0, then the stream resumes with no bundle lost or duplicated.
- Flush with a held stage: stall[2]=1 and flush[1]=1 in the same cycle -> stage_valid[1]=0 next cycle, stage 2 keeps its value, stage 0 is still held.
- Flush forwarding: flush[0]=1 with no stalls, stage 0 holding reg_we=1 -> next cycle stage_valid[1]=0 and reg_we in slice 1 is 0.
- Async reset with 3 valid stages: rst_n pulsed low between edges -> stage_valid becomes 000 immediately with no clock edge. After release, in_ctrl 0x5A appears in stage 0 after the first edge.
- Parity, with `CTRL_PIPE_PARITY_EN`: force one payload bit of stage 1 -> parity_err=3'b010. Without the macro, parity_err stays 0.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle (ALU/imm/mem/reg/branch
// controls) through STAGES registered stages. Every stage has a valid bit and
// its own stall and flush. Side-effecting bits (SE_MASK) are forced low on
// any stage that does not hold a valid bundle.
// Optional feature: define CTRL_PIPE_PARITY_EN to store a per-stage even
// parity bit and report mismatches on parity_err. Without it, parity_err is
// tied to 0.

module ctrl_pipe #(
    parameter int                CTRL_W  = 24,
    parameter int                STAGES  = 3,
    parameter logic [CTRL_W-1:0] SE_MASK = CTRL_W'(24'h000201)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       in_ready,
    input  logic [STAGES-1:0]          stall,
    input  logic [STAGES-1:0]          flush,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*CTRL_W-1:0]   stage_ctrl,
    output logic [STAGES-1:0]          parity_err
);

    logic [STAGES-1:0]             hold;
    logic [STAGES-1:0]             advance;
    logic [STAGES-1:0]             valid_q;
    logic [STAGES-1:0]             valid_d;
    logic [STAGES-1:0][CTRL_W-1:0] payload_q;
    logic [STAGES-1:0][CTRL_W-1:0] payload_d;

    // A stall anywhere downstream freezes this stage too: hold[i] = |stall[i..end]
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc     = acc | stall[i];
            hold[i] = acc;
        end
    end

    assign in_ready = ~hold[0];

    // Per-stage decision: flush kills, hold keeps, otherwise capture from upstream (or bubble)
    always_comb begin
        valid_d = valid_q;
        advance = '0;
        if (flush[0]) begin
            valid_d[0] = 1'b0;
        end else if (!hold[0]) begin
            valid_d[0] = in_valid;
            advance[0] = 1'b1;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (flush[i]) begin
                valid_d[i] = 1'b0;
            end else if (!hold[i]) begin
                if (stall[i-1] || flush[i-1]) begin
                    valid_d[i] = 1'b0;
                end else begin
                    valid_d[i] = valid_q[i-1];
                    advance[i] = 1'b1;
                end
            end
        end
    end

    // Payload moves only on an advance; flushed, held and bubbled stages keep their old bits
    always_comb begin
        payload_d = payload_q;
        if (advance[0]) begin
            payload_d[0] = in_ctrl;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (advance[i]) begin
                payload_d[i] = payload_q[i-1];
            end
        end
    end

    // Valid and payload registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign stage_valid = valid_q;

    // Side-effect bits of empty or killed slots read as 0 so no write-enable leaks downstream
    always_comb begin
        stage_ctrl = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_ctrl[i*CTRL_W +: CTRL_W] = payload_q[i] & ~(valid_q[i] ? '0 : SE_MASK);
        end
    end

`ifdef CTRL_PIPE_PARITY_EN
    logic [STAGES-1:0] parity_q;
    logic [STAGES-1:0] parity_d;

    // Parity is generated once at stage 0 entry and then travels with its payload
    always_comb begin
        parity_d = parity_q;
        if (advance[0]) begin
            parity_d[0] = ^in_ctrl;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (advance[i]) begin
                parity_d[i] = parity_q[i-1];
            end
        end
    end

    // Parity registers, cleared with the payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    // A valid stage whose payload no longer matches its stored parity has been corrupted
    always_comb begin
        parity_err = '0;
        for (int i = 0; i < STAGES; i++) begin
            parity_err[i] = valid_q[i] & ((^payload_q[i]) != parity_q[i]);
        end
    end
`else
    assign parity_err = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: self-checking bench for ctrl_pipe (STAGES=3, CTRL_W=24).
// Accepted bundles are queued as expected last-stage outputs and popped by a
// monitor when stage 2 presents new content.

module tb_ctrl_pipe;

    localparam int                CTRL_W  = 24;
    localparam int                STAGES  = 3;
    localparam logic [CTRL_W-1:0] SE_MASK = 24'h000201;

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic [CTRL_W-1:0]        in_ctrl;
    logic                     in_ready;
    logic [STAGES-1:0]        stall;
    logic [STAGES-1:0]        flush;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*CTRL_W-1:0] stage_ctrl;
    logic [STAGES-1:0]        parity_err;

    int                compared   = 0;
    int                mismatched = 0;
    logic [CTRL_W-1:0] expQ[$];
    bit                sbEn = 1'b0;
    bit                monNew;
    logic [CTRL_W-1:0] monExp;

    ctrl_pipe #(
        .CTRL_W (CTRL_W),
        .STAGES (STAGES),
        .SE_MASK(SE_MASK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ctrl    (in_ctrl),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .stage_valid(stage_valid),
        .stage_ctrl (stage_ctrl),
        .parity_err (parity_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CTRL_W-1:0] sliceOf(input int s);
        return stage_ctrl[s*CTRL_W +: CTRL_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_ctrl  = '0;
        stall    = '0;
        flush    = '0;
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) tick();
    endtask

    // Scoreboard monitor: stage 2 has new content after an edge where stall[2] was low
    always @(posedge clk) begin
        monNew = !stall[STAGES-1];
        #1;
        if (sbEn) begin
            if (stage_valid[STAGES-1] && monNew) begin
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL sb_unexpected: got %h, expected no output", sliceOf(STAGES-1));
                end else begin
                    monExp = expQ.pop_front();
                    if (sliceOf(STAGES-1) !== monExp) begin
                        mismatched++;
                        $display("[TB] FAIL sb_out: got %h, expected %h", sliceOf(STAGES-1), monExp);
                    end
                end
            end
            if (!stage_valid[STAGES-1]) begin
                compared++;
                if ((sliceOf(STAGES-1) & SE_MASK) !== '0) begin
                    mismatched++;
                    $display("[TB] FAIL sb_bubble_se: got %h, expected 000000", sliceOf(STAGES-1) & SE_MASK);
                end
            end
            compared++;
            if (parity_err !== '0) begin
                mismatched++;
                $display("[TB] FAIL sb_parity_quiet: got %b, expected 000", parity_err);
            end
        end
    end

    task automatic test_reset();
        $display("[TB] running test_reset");
        rst_n = 1'b0;
        idle();
        #2;
        compared++;
        if ({stage_valid, stage_ctrl, parity_err} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got valid=%b ctrl=%h perr=%b, expected all 0", stage_valid, stage_ctrl, parity_err);
        end
        in_valid = 1'b1;
        in_ctrl  = 24'h0000AB;
        tick();
        compared++;
        if ({stage_valid, stage_ctrl} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_edge: got valid=%b ctrl=%h, expected all 0", stage_valid, stage_ctrl);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_ready_free: got %b, expected 1", in_ready);
        end
        stall = 3'b010;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ready_stall: got %b, expected 0", in_ready);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        compared++;
        if (stage_valid !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_release: got %b, expected 000", stage_valid);
        end
    endtask

    task automatic test_streaming();
        logic [CTRL_W-1:0] vals [3];
        $display("[TB] running test_streaming");
        vals[0] = 24'h000011;
        vals[1] = 24'h000022;
        vals[2] = 24'h000033;
        sbEn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_ctrl  = vals[k];
            expQ.push_back(vals[k]);
            tick();
            if (k == 0) begin
                compared++;
                if ({stage_valid[0], sliceOf(0)} !== {1'b1, vals[0]}) begin
                    mismatched++;
                    $display("[TB] FAIL stream_stage0: got v=%b %h, expected v=1 %h", stage_valid[0], sliceOf(0), vals[0]);
                end
            end
        end
        compared++;
        if ({stage_valid[2], sliceOf(2)} !== {1'b1, vals[0]}) begin
            mismatched++;
            $display("[TB] FAIL stream_latency: got v=%b %h, expected v=1 %h", stage_valid[2], sliceOf(2), vals[0]);
        end
        drain(4);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL stream_drain: got %0d left, expected 0", expQ.size());
        end
    endtask

    task automatic test_middle_stall();
        logic [CTRL_W-1:0] vals [5];
        logic [CTRL_W-1:0] s0Before;
        logic [CTRL_W-1:0] s1Before;
        logic [1:0]        vBefore;
        int                idx;
        $display("[TB] running test_middle_stall");
        for (int k = 0; k < 5; k++) vals[k] = 24'h000201 + 24'(2 * k);
        idx = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            stall    = (cyc == 2 || cyc == 3) ? 3'b010 : 3'b000;
            flush    = '0;
            in_valid = (idx < 5);
            in_ctrl  = (idx < 5) ? vals[idx] : '0;
            #1;
            compared++;
            if (in_ready !== (stall == 3'b000)) begin
                mismatched++;
                $display("[TB] FAIL mid_ready: got %b, expected %b", in_ready, (stall == 3'b000));
            end
            s0Before = sliceOf(0);
            s1Before = sliceOf(1);
            vBefore  = stage_valid[1:0];
            if (in_valid && in_ready) expQ.push_back(in_ctrl);
            tick();
            if (in_valid && stall == 3'b000) idx++;
            if (cyc == 2 || cyc == 3) begin
                compared++;
                if ({vBefore, s0Before, s1Before} !== {stage_valid[1:0], sliceOf(0), sliceOf(1)}) begin
                    mismatched++;
                    $display("[TB] FAIL mid_frozen: got v=%b %h %h, expected v=%b %h %h", stage_valid[1:0], sliceOf(0), sliceOf(1), vBefore, s0Before, s1Before);
                end
                compared++;
                if (stage_valid[2] !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL mid_bubble: got %b, expected 0", stage_valid[2]);
                end
            end
        end
        drain(4);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL mid_drain: got %0d left, expected 0", expQ.size());
        end
    endtask

    task automatic test_flush_held();
        $display("[TB] running test_flush_held");
        in_valid = 1'b1;
        in_ctrl  = 24'h000031; expQ.push_back(in_ctrl); tick();
        in_ctrl  = 24'h000201; tick();
        in_ctrl  = 24'h000033; expQ.push_back(in_ctrl); tick();
        in_ctrl  = 24'h000034;
        stall    = 3'b100;
        flush    = 3'b010;
        #1;
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fh_ready: got %b, expected 0", in_ready);
        end
        tick();
        compared++;
        if (stage_valid !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL fh_valid: got %b, expected 101", stage_valid);
        end
        compared++;
        if ({sliceOf(2), sliceOf(0)} !== {24'h000031, 24'h000033}) begin
            mismatched++;
            $display("[TB] FAIL fh_held: got %h %h, expected 000031 000033", sliceOf(2), sliceOf(0));
        end
        compared++;
        if ((sliceOf(1) & SE_MASK) !== '0) begin
            mismatched++;
            $display("[TB] FAIL fh_se_gate: got %h, expected 000000", sliceOf(1) & SE_MASK);
        end
        stall = '0;
        flush = '0;
        expQ.push_back(in_ctrl);
        tick();
        compared++;
        if (stage_valid !== 3'b011) begin
            mismatched++;
            $display("[TB] FAIL fh_resume: got %b, expected 011", stage_valid);
        end
        drain(4);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL fh_drain: got %0d left, expected 0", expQ.size());
        end
    endtask

    task automatic test_flush_forward();
        $display("[TB] running test_flush_forward");
        in_valid = 1'b1;
        in_ctrl  = 24'h00020F;
        tick();
        idle();
        flush = 3'b001;
        tick();
        compared++;
        if (stage_valid !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL ff_valid: got %b, expected 000", stage_valid);
        end
        compared++;
        if (sliceOf(1)[9] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ff_reg_we: got %b, expected 0", sliceOf(1)[9]);
        end
        drain(4);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL ff_drain: got %0d left, expected 0", expQ.size());
        end
    endtask

    task automatic test_async_reset();
        $display("[TB] running test_async_reset");
        sbEn = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_ctrl = 24'h000241 + 24'(k);
            tick();
        end
        compared++;
        if (stage_valid !== 3'b111) begin
            mismatched++;
            $display("[TB] FAIL ar_full: got %b, expected 111", stage_valid);
        end
        idle();
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({stage_valid, stage_ctrl} !== '0) begin
            mismatched++;
            $display("[TB] FAIL ar_async_clear: got valid=%b ctrl=%h, expected all 0", stage_valid, stage_ctrl);
        end
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 24'h00005A;
        expQ.push_back(in_ctrl);
        sbEn = 1'b1;
        tick();
        compared++;
        if ({stage_valid, sliceOf(0)} !== {3'b001, 24'h00005A}) begin
            mismatched++;
            $display("[TB] FAIL ar_first_accept: got v=%b %h, expected v=001 00005a", stage_valid, sliceOf(0));
        end
        drain(4);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL ar_drain: got %0d left, expected 0", expQ.size());
        end
    endtask

    task automatic test_back_to_back();
        logic expReady;
        $display("[TB] running test_back_to_back");
        for (int cyc = 0; cyc < 40; cyc++) begin
            stall    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            flush    = '0;
            in_valid = 1'($urandom_range(0, 1));
            in_ctrl  = 24'($urandom);
            expReady = (stall == 3'b000);
            #1;
            compared++;
            if (in_ready !== expReady) begin
                mismatched++;
                $display("[TB] FAIL b2b_ready: got %b, expected %b", in_ready, expReady);
            end
            if (in_valid && expReady) expQ.push_back(in_ctrl);
            tick();
        end
        drain(5);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_drain: got %0d left, expected 0", expQ.size());
        end
    endtask

    task automatic test_parity();
        $display("[TB] running test_parity");
        sbEn = 1'b0;
        in_valid = 1'b1;
        in_ctrl = 24'h000050; tick();
        in_ctrl = 24'h000061; tick();
        in_ctrl = 24'h000072; tick();
        idle();
        stall = 3'b111;
        #1;
        compared++;
        if (parity_err !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL parity_clean: got %b, expected 000", parity_err);
        end
`ifdef CTRL_PIPE_PARITY_EN
        force dut.payload_q[1][1] = 1'b1;
        #1;
        compared++;
        if (parity_err !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL parity_inject: got %b, expected 010", parity_err);
        end
        release dut.payload_q[1][1];
`else
        tick();
        compared++;
        if (parity_err !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL parity_tied: got %b, expected 000", parity_err);
        end
`endif
        stall = '0;
        flush = 3'b111;
        tick();
        drain(3);
        compared++;
        if (stage_valid !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL parity_flushed: got %b, expected 000", stage_valid);
        end
        sbEn = 1'b1;
    endtask

    // Time limit so a stuck run still ends with a report
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_streaming();
        test_middle_stall();
        test_flush_held();
        test_flush_forward();
        test_async_reset();
        test_back_to_back();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
